// File: rtl/sev_seg_scan_driver.sv
// rtl/sev_seg_scan_driver.sv - multi-digit 7-segment scan driver with frame-synchronous double buffering
module sev_seg_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int BLANK_CYC      = 8,
   parameter int ACTIVE_LOW_SEG = 1,
   parameter int ACTIVE_LOW_AN  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   value_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      blank_lz,
   output logic [6:0]                seg_out,
   output logic                      dp_out,
   output logic [NUM_DIGITS-1:0]     an_out,
   output logic                      frame_tick
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);
   localparam logic SEG_INV = (ACTIVE_LOW_SEG != 0);
   localparam logic AN_INV  = (ACTIVE_LOW_AN != 0);
   localparam logic [6:0] SEG_OFF = {7{SEG_INV}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_INV}};

   logic [PW-1:0]           prescaler;
   logic [DW-1:0]           digit_idx;
   logic                    pending;
   logic [4*NUM_DIGITS-1:0] sh_val, disp_val, show_val;
   logic [NUM_DIGITS-1:0]   sh_dp, disp_dp, show_dp;
   logic                    sh_lz, disp_lz, show_lz;
   logic                    commit;
   logic [NUM_DIGITS-1:0]   suppress, an_sel;
   logic                    zero_run;
   logic [3:0]              cur_nib;
   logic                    cur_dp, cur_sup;
   logic [6:0]              lit;

   // Lit pattern (1 = segment on), gfedcba order.
   function automatic logic [6:0] font_lit(input logic [3:0] h);
      case (h)
         4'h0: font_lit = ~7'b1000000;
         4'h1: font_lit = ~7'b1111001;
         4'h2: font_lit = ~7'b0100100;
         4'h3: font_lit = ~7'b0110000;
         4'h4: font_lit = ~7'b0011001;
         4'h5: font_lit = ~7'b0010010;
         4'h6: font_lit = ~7'b0000010;
         4'h7: font_lit = ~7'b1111000;
         4'h8: font_lit = ~7'b0000000;
         4'h9: font_lit = ~7'b0010000;
         4'hA: font_lit = ~7'b0001000;
         4'hB: font_lit = ~7'b0000011;
         4'hC: font_lit = ~7'b1000110;
         4'hD: font_lit = ~7'b0100001;
         4'hE: font_lit = ~7'b0000110;
         default: font_lit = ~7'b0001110;
      endcase
   endfunction

   // The frame that starts on a commit must already render the new shadow.
   assign commit   = frame_tick & pending;
   assign show_val = commit ? sh_val : disp_val;
   assign show_dp  = commit ? sh_dp  : disp_dp;
   assign show_lz  = commit ? sh_lz  : disp_lz;

   always_comb begin
      suppress = '0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (show_val[4*i +: 4] == 4'h0);
         if (i != 0) suppress[i] = zero_run & show_lz;
      end
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      cur_sup = 1'b0;
      an_sel  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx == DW'(i)) begin
            cur_nib   = show_val[4*i +: 4];
            cur_dp    = show_dp[i];
            cur_sup   = suppress[i];
            an_sel[i] = 1'b1;
         end
      end
      lit = cur_sup ? 7'h00 : font_lit(cur_nib);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler  <= '0;
         digit_idx  <= '0;
         pending    <= 1'b0;
         sh_val     <= '0;
         sh_dp      <= '0;
         sh_lz      <= 1'b0;
         disp_val   <= '0;
         disp_dp    <= '0;
         disp_lz    <= 1'b0;
         frame_tick <= 1'b0;
         seg_out    <= SEG_OFF;
         dp_out     <= SEG_INV;
         an_out     <= AN_OFF;
      end else begin
         if (commit) begin
            disp_val <= sh_val;
            disp_dp  <= sh_dp;
            disp_lz  <= sh_lz;
            pending  <= 1'b0;
         end
         // A load coinciding with a commit stays pending for the next frame.
         if (load) begin
            sh_val  <= value_in;
            sh_dp   <= dp_in;
            sh_lz   <= blank_lz;
            pending <= 1'b1;
         end
         if (!enable) begin
            prescaler  <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
            seg_out    <= SEG_OFF;
            dp_out     <= SEG_INV;
            an_out     <= AN_OFF;
         end else begin
            if (prescaler == P_LAST) begin
               prescaler  <= '0;
               digit_idx  <= (digit_idx == D_LAST) ? '0 : digit_idx + 1'b1;
               frame_tick <= (digit_idx == D_LAST);
            end else begin
               prescaler  <= prescaler + 1'b1;
               frame_tick <= 1'b0;
            end
            seg_out <= SEG_INV ? ~lit : lit;
            dp_out  <= cur_dp ^ SEG_INV;
            an_out  <= (int'(prescaler) < BLANK_CYC) ? AN_OFF : (AN_INV ? ~an_sel : an_sel);
         end
      end
   end

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// tb/tb_sev_seg_scan_driver.sv - self-checking bench for sev_seg_scan_driver against a behavioural model
module tb_sev_seg_scan_driver;
   localparam int ND = 4;
   localparam int RD = 4;
   localparam int BC = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b1;
   logic load = 1'b0;
   logic [15:0] value_in = '0;
   logic [3:0]  dp_in = '0;
   logic blank_lz = 1'b0;
   logic [6:0] seg_out;
   logic dp_out;
   logic [3:0] an_out;
   logic frame_tick;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   sev_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BC),
                         .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .load(load), .value_in(value_in),
      .dp_in(dp_in), .blank_lz(blank_lz), .seg_out(seg_out), .dp_out(dp_out),
      .an_out(an_out), .frame_tick(frame_tick));

   always #5 clk = ~clk;

   logic [6:0] font_al [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Model: s counts enabled cycles since scan start; digit/phase follow by division.
   int s = 0;
   logic [15:0] m_sh_v = '0, m_d_v = '0, m_tmp;
   logic [3:0]  m_sh_dp = '0, m_d_dp = '0;
   logic m_sh_lz = 1'b0, m_d_lz = 1'b0, m_pend = 1'b0;
   logic [6:0] exp_seg = 7'h7F;
   logic exp_dp = 1'b1;
   logic [3:0] exp_an = 4'hF;
   logic exp_tick = 1'b0;

   always @(posedge clk or posedge rst) begin
      int dig, ph;
      bit supp;
      if (rst) begin
         s = 0; m_sh_v = '0; m_d_v = '0; m_sh_dp = '0; m_d_dp = '0;
         m_sh_lz = 1'b0; m_d_lz = 1'b0; m_pend = 1'b0;
         exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_tick = 1'b0;
      end else begin
         if (exp_tick && m_pend) begin
            m_d_v = m_sh_v; m_d_dp = m_sh_dp; m_d_lz = m_sh_lz; m_pend = 1'b0;
         end
         if (load) begin
            m_sh_v = value_in; m_sh_dp = dp_in; m_sh_lz = blank_lz; m_pend = 1'b1;
         end
         if (enable) begin
            dig = (s / RD) % ND;
            ph  = s % RD;
            exp_an = (ph < BC) ? 4'hF : ~(4'b0001 << dig);
            m_tmp = m_d_v >> (4 * dig);
            supp = m_d_lz && (dig > 0) && (m_tmp == 16'h0);
            exp_seg = supp ? 7'h7F : font_al[m_tmp[3:0]];
            exp_dp = !m_d_dp[dig];
            exp_tick = ((s + 1) % (RD * ND)) == 0;
            s = s + 1;
         end else begin
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_tick = 1'b0; s = 0;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_seg", 32'(seg_out), 32'(exp_seg));
         check("model_dp", 32'(dp_out), 32'(exp_dp));
         check("model_an", 32'(an_out), 32'(exp_an));
         check("model_tick", 32'(frame_tick), 32'(exp_tick));
      end
   end

   task automatic wait_an(input logic [3:0] t, input string nm);
      int n = 0;
      while (an_out !== t && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (an_out !== t) check({nm, "_timeout"}, 32'(an_out), 32'(t));
   endtask

   task automatic wait_tick(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 40);
      if (!frame_tick) check({nm, "_tick_timeout"}, 32'(frame_tick), 32'd1);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic z);
      value_in = v; dp_in = d; blank_lz = z; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      int n;
      int cnt [4];
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_an", 32'(an_out), 32'hF);
      check("rst_seg", 32'(seg_out), 32'h7F);
      check("rst_tick", 32'(frame_tick), 32'h0);
      rst = 1'b0;

      // Frame period and anode walk
      wait_tick("t1a");
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_tick && n < 40);
      check("tick_period", 32'(n), 32'd16);
      cnt = '{0, 0, 0, 0};
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) if (an_out == ~(4'b0001 << d)) cnt[d]++;
      end
      for (int d = 0; d < 4; d++) check("an_lit_cycles", 32'(cnt[d]), 32'd3);

      // Double buffering: mid-frame load shows only after frame_tick
      wait_tick("t2a");
      @(negedge clk);
      do_load(16'h12AF, 4'h0, 1'b0);
      wait_an(4'b0111, "t2b");
      check("no_tear_d3", 32'(seg_out), 32'(7'b1000000));
      wait_tick("t2c");
      wait_an(4'b1110, "t2d");
      check("F_digit0", 32'(seg_out), 32'(7'b0001110));
      wait_an(4'b0111, "t2e");
      check("1_digit3", 32'(seg_out), 32'(7'b1111001));

      // Leading-zero suppression
      @(negedge clk);
      do_load(16'h0070, 4'h0, 1'b1);
      wait_tick("t3a");
      wait_an(4'b1110, "t3b"); check("lz_d0", 32'(seg_out), 32'(7'b1000000));
      wait_an(4'b1101, "t3c"); check("lz_d1", 32'(seg_out), 32'(7'b1111000));
      wait_an(4'b1011, "t3d"); check("lz_d2", 32'(seg_out), 32'(7'b1111111));
      wait_an(4'b0111, "t3e"); check("lz_d3", 32'(seg_out), 32'(7'b1111111));
      do_load(16'h0070, 4'h0, 1'b0);
      wait_tick("t3f");
      wait_an(4'b1011, "t3g"); check("nolz_d2", 32'(seg_out), 32'(7'b1000000));
      wait_an(4'b0111, "t3h"); check("nolz_d3", 32'(seg_out), 32'(7'b1000000));

      // A, B, then C coincident with frame_tick
      wait_tick("t4a");
      repeat (3) @(negedge clk);
      do_load(16'h9999, 4'h0, 1'b0);
      @(negedge clk);
      do_load(16'h8888, 4'h0, 1'b0);
      wait_tick("t4b");
      do_load(16'h1111, 4'h0, 1'b0);
      wait_an(4'b1110, "t4c"); check("frame_shows_B", 32'(seg_out), 32'(7'b0000000));
      wait_tick("t4d");
      wait_an(4'b1110, "t4e"); check("next_shows_C", 32'(seg_out), 32'(7'b1111001));

      // Decimal point and enable gating
      do_load(16'h1234, 4'b0100, 1'b0);
      wait_tick("t5a");
      wait_an(4'b1011, "t5b"); check("dp_d2_lit", 32'(dp_out), 32'd0);
      wait_an(4'b0111, "t5c"); check("dp_d3_dark", 32'(dp_out), 32'd1);
      enable = 1'b0;
      repeat (5) begin @(negedge clk); check("en0_an", 32'(an_out), 32'hF); end
      enable = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (an_out == 4'hF && n < 20);
      check("restart_d0", 32'(an_out), 32'(4'b1110));

      // Async reset mid-scan discards pending load
      wait_tick("t6a");
      @(negedge clk);
      do_load(16'h5555, 4'h0, 1'b0);
      wait_an(4'b1011, "t6b");
      #2 rst = 1'b1;
      #1;
      check("arst_an", 32'(an_out), 32'hF);
      check("arst_seg", 32'(seg_out), 32'h7F);
      check("arst_tick", 32'(frame_tick), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (an_out == 4'hF && n < 20);
      check("post_rst_d0", 32'(an_out), 32'(4'b1110));
      wait_tick("t6c");
      wait_tick("t6d");
      wait_an(4'b1110, "t6e");
      check("pending_dropped", 32'(seg_out), 32'(7'b1000000));

      // Randomised traffic against the model
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         enable   = ($urandom_range(0, 19) != 0);
         load     = ($urandom_range(0, 5) == 0);
         value_in = 16'($urandom);
         if ($urandom_range(0, 2) == 0) value_in[15:8] = 8'h00;
         dp_in    = 4'($urandom);
         blank_lz = 1'($urandom);
      end
      @(negedge clk);
      load = 1'b0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
